// File: rtl/counters_pkg.sv
// rtl/counters_pkg.sv - shared constants and helpers for the shift-register counters
package counters_pkg;

  // Counting mode encodings
  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;

  // Shift direction encodings
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Ceiling log2 that never returns less than one bit, so narrow ports stay legal
  function automatic int clog2_safe(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shift_ring_decode.sv
// rtl/shift_ring_decode.sv - legality check and phase-index decode for Johnson/ring registers
module shift_ring_decode
  import counters_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2_safe(2 * N)
) (
  input  logic [N-1:0]  q,
  input  logic          mode_r,
  output logic          legal,
  output logic [IW-1:0] idx
);

  int ones;
  int edges;
  int pos;
  int idx_i;

  // Count set bits, remember the highest set bit, and count adjacent-bit transitions
  always_comb begin
    ones  = 0;
    pos   = 0;
    edges = 0;
    for (int i = 0; i < N; i++) begin
      if (q[i]) begin
        ones = ones + 1;
        pos  = i;
      end
    end
    for (int i = 0; i < N - 1; i++) begin
      if (q[i] != q[i+1]) edges = edges + 1;
    end
  end

  // Ring is one-hot; Johnson states have a single boundary between a ones run and a zeros run
  always_comb begin
    legal = 1'b0;
    idx_i = 0;
    if (mode_r == MODE_RING) begin
      legal = (ones == 1);
      idx_i = N - 1 - pos;
    end else begin
      legal = (edges <= 1);
      if (q[N-1])         idx_i = ones;
      else if (ones == 0) idx_i = 0;
      else                idx_i = 2 * N - ones;
    end
    idx = legal ? IW'(idx_i) : '0;
  end

endmodule

// File: rtl/shift_ring_counter.sv
// rtl/shift_ring_counter.sv - Johnson/ring shift counter with load, self-correction and terminal count
module shift_ring_counter
  import counters_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2_safe(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [IW-1:0] idx,
  output logic          legal,
  output logic          tc,
  output logic          err
);

  // Bit 0 alone is a legal state in both modes, so it is the universal restart point
  localparam logic [N-1:0] Q_RESET = {{(N-1){1'b0}}, 1'b1};

  logic          mode_r;
  logic          mode_chg;
  logic [N-1:0]  q_shift;
  logic [N-1:0]  q_nxt;
  logic          err_nxt;
  logic [IW-1:0] idx_last;

  shift_ring_decode #(
    .N  (N),
    .IW (IW)
  ) u_decode (
    .q      (q),
    .mode_r (mode_r),
    .legal  (legal),
    .idx    (idx)
  );

  assign mode_chg = (mode != mode_r);
  assign idx_last = (mode_r == MODE_RING) ? IW'(N - 1) : IW'(2 * N - 1);

  // One-step shift: Johnson feeds back the inverted end bit, ring feeds it back unchanged
  always_comb begin
    q_shift = q;
    if (mode_r == MODE_JOHNSON) begin
      if (dir == DIR_LEFT) q_shift = {q[N-2:0], ~q[N-1]};
      else                 q_shift = {~q[0], q[N-1:1]};
    end else begin
      if (dir == DIR_LEFT) q_shift = {q[N-2:0], q[N-1]};
      else                 q_shift = {q[0], q[N-1:1]};
    end
  end

  // Priority: load, then mode change, then illegal-state correction, then shift, else hold
  always_comb begin
    q_nxt   = q;
    err_nxt = err;
    if (load) begin
      q_nxt = load_val;
    end else if (mode_chg) begin
      q_nxt = Q_RESET;
    end else if (en && !legal) begin
      q_nxt   = Q_RESET;
      err_nxt = 1'b1;
    end else if (en) begin
      q_nxt = q_shift;
    end
  end

  // Terminal count marks the step that wraps the phase, only when a real shift happens
  always_comb begin
    tc = 1'b0;
    if (en && legal && !load && !mode_chg) begin
      tc = (dir == DIR_LEFT) ? (idx == '0) : (idx == idx_last);
    end
  end

  // State registers; mode_r follows mode every cycle, err only clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= Q_RESET;
      mode_r <= mode;
      err    <= 1'b0;
    end else begin
      q      <= q_nxt;
      mode_r <= mode;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_shift_ring_counter.sv
// tb/tb_shift_ring_counter.sv - vector table and randomized reference-model bench for shift_ring_counter
module tb_shift_ring_counter;

  localparam int N  = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst, en, mode, dir, load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  q;
  logic [IW-1:0] idx;
  logic          legal, tc, err;

  int ncmp  = 0;
  int nfail = 0;

  shift_ring_counter #(.N(N), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .idx      (idx),
    .legal    (legal),
    .tc       (tc),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model: legal states are tracked as a phase number on a circle
  logic [N-1:0] m_q;
  logic         m_mode;
  logic         m_err;
  logic         m_valid = 1'b0;

  function automatic int period_of(input logic md);
    return md ? N : 2 * N;
  endfunction

  // The register pattern that sits at phase k of each sequence
  function automatic logic [N-1:0] q_of(input int k, input logic md);
    logic [N-1:0] v;
    v = '0;
    for (int b = 0; b < N; b++) begin
      if (md)         v[b] = (b == N - 1 - k);
      else if (k <= N) v[b] = (b >= N - k);
      else            v[b] = (b < 2 * N - k);
    end
    return v;
  endfunction

  function automatic int phase_of(input logic [N-1:0] v, input logic md);
    for (int k = 0; k < period_of(md); k++) begin
      if (q_of(k, md) == v) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    int ph, per, exp_idx, exp_tc;
    ph  = phase_of(m_q, m_mode);
    per = period_of(m_mode);
    exp_idx = (ph < 0) ? 0 : ph;
    exp_tc  = (en && ph >= 0 && !load && mode == m_mode &&
               (dir ? ph == 0 : ph == per - 1)) ? 1 : 0;
    check("model q", int'(q), int'(m_q));
    check("model legal", int'(legal), (ph >= 0) ? 1 : 0);
    check("model idx", int'(idx), exp_idx);
    check("model tc", int'(tc), exp_tc);
    check("model err", int'(err), int'(m_err));
  endtask

  task automatic model_step();
    int ph, per;
    ph  = phase_of(m_q, m_mode);
    per = period_of(m_mode);
    if (rst) begin
      m_q = q_of(per_last(mode), mode); m_mode = mode; m_err = 1'b0; m_valid = 1'b1;
    end else if (load) begin
      m_q = load_val; m_mode = mode;
    end else if (mode != m_mode) begin
      m_mode = mode; m_q = q_of(per_last(mode), mode);
    end else if (en && ph < 0) begin
      m_q = q_of(per_last(m_mode), m_mode); m_err = 1'b1;
    end else if (en) begin
      ph = dir ? (ph + per - 1) % per : (ph + 1) % per;
      m_q = q_of(ph, m_mode);
    end
  endtask

  // The restart pattern is the last phase of the period (bit 0 only)
  function automatic int per_last(input logic md);
    return period_of(md) - 1;
  endfunction

  // Drive inputs away from the edge and sample combinational outputs before it
  task automatic drive(input logic r, e, m, d, l, input logic [N-1:0] lv);
    @(negedge clk);
    rst = r; en = e; mode = m; dir = d; load = l; load_val = lv;
    #1;
    if (m_valid) model_compare();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
  endtask

  typedef struct {
    logic         r, e, m, d, l;
    logic [N-1:0] lv;
    logic         chk;
    logic [N-1:0] eq;
    int           eidx;
    logic         elegal, etc, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, e, m, d, l, input logic [N-1:0] lv,
                              input logic c, input logic [N-1:0] eq, input int ei,
                              input logic el, et, ee);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.d = d; v.l = l; v.lv = lv;
    v.chk = c; v.eq = eq; v.eidx = ei; v.elegal = el; v.etc = et; v.eerr = ee;
    vecs.push_back(v);
  endfunction

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    m_q = '0; m_mode = 1'b0; m_err = 1'b0;

    // Johnson right through a full period and a bit
    add(1,0,0,0,0,4'b0000, 0,4'b0000,0,0,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0001,7,1,1,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0000,0,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b1000,1,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b1100,2,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b1110,3,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b1111,4,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0111,5,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0011,6,1,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0001,7,1,1,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0000,0,1,0,0);
    // Johnson left from reset
    add(1,0,0,0,0,4'b0000, 0,4'b0000,0,0,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b0001,7,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b0011,6,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b0111,5,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b1111,4,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b1110,3,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b1100,2,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b1000,1,1,0,0);
    add(0,1,0,1,0,4'b0000, 1,4'b0000,0,1,1,0);
    add(0,1,0,1,0,4'b0000, 1,4'b0001,7,1,0,0);
    // Ring mode via load, right then left
    add(0,0,1,0,1,4'b0001, 0,4'b0000,0,0,0,0);
    add(0,1,1,0,0,4'b0000, 1,4'b0001,3,1,1,0);
    add(0,1,1,0,0,4'b0000, 1,4'b1000,0,1,0,0);
    add(0,1,1,0,0,4'b0000, 1,4'b0100,1,1,0,0);
    add(0,1,1,0,0,4'b0000, 1,4'b0010,2,1,0,0);
    add(0,1,1,1,0,4'b0000, 1,4'b0001,3,1,0,0);
    add(0,0,1,1,0,4'b0000, 1,4'b0010,2,1,0,0);
    // Illegal Johnson load, hold, correction, sticky err
    add(1,0,0,0,0,4'b0000, 0,4'b0000,0,0,0,0);
    add(0,0,0,0,1,4'b0101, 0,4'b0000,0,0,0,0);
    add(0,0,0,0,0,4'b0000, 1,4'b0101,0,0,0,0);
    add(0,1,0,0,0,4'b0000, 1,4'b0101,0,0,0,0);
    add(0,0,0,0,0,4'b0000, 1,4'b0001,7,1,0,1);
    add(0,1,0,0,0,4'b0000, 1,4'b0001,7,1,1,1);
    add(0,1,0,0,0,4'b0000, 1,4'b0000,0,1,0,1);
    add(0,0,0,0,0,4'b0000, 1,4'b1000,1,1,0,1);
    // Reset beats load and en; load with mode change suppresses tc
    add(1,1,0,0,1,4'b1010, 1,4'b1000,1,1,0,1);
    add(0,0,0,0,0,4'b0000, 1,4'b0001,7,1,0,0);
    add(0,1,1,0,1,4'b0100, 1,4'b0001,7,1,0,0);
    add(0,0,1,0,0,4'b0000, 1,4'b0100,1,1,0,0);
    // Mode change from Johnson 1100 restarts without shifting
    add(0,0,0,0,1,4'b1100, 0,4'b0000,0,0,0,0);
    add(0,1,1,0,0,4'b0000, 1,4'b1100,2,1,0,0);
    add(0,1,1,0,0,4'b0000, 1,4'b0001,3,1,1,0);
    add(0,0,1,0,0,4'b0000, 1,4'b1000,0,1,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].d, vecs[i].l, vecs[i].lv);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d q", i), int'(q), int'(vecs[i].eq));
        check($sformatf("vec%0d idx", i), int'(idx), vecs[i].eidx);
        check($sformatf("vec%0d legal", i), int'(legal), int'(vecs[i].elegal));
        check($sformatf("vec%0d tc", i), int'(tc), int'(vecs[i].etc));
        check($sformatf("vec%0d err", i), int'(err), int'(vecs[i].eerr));
      end
      tick();
    end

    // Randomized traffic against the phase model
    drive(1, 0, 0, 0, 0, '0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic r, l, m;
      r = ($urandom_range(63) == 0);
      l = ($urandom_range(9) == 0);
      m = ($urandom_range(19) == 0) ? ~m_mode : m_mode;
      drive(r, ($urandom_range(3) != 0), m, 1'($urandom_range(1)), l, N'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/shift_ring_counter.md
Name: shift_ring_counter

Overview:
- Parametrised shift-register counter: the generalised successor of the fixed Johnson counter.
- Runs in Johnson (twisted-ring, 2N states) or ring (one-hot, N states) mode and shifts in either direction.
- Adds enable, parallel load, illegal-state self-correction, phase-index decode and a terminal-count pulse.
- Used as a phase or sequence generator and as a glitch-free decoded timing source in the Counters group.

Parameters:
- N, default 8: register width in bits; must be ≥ 2.
- IW, default $clog2(2*N): width of the phase-index output.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance one state this cycle.
- mode  input  1  0 = Johnson, 1 = ring.
- dir  input  1  0 = shift right (toward bit 0), 1 = shift left.
- load  input  1  load load_val this cycle.
- load_val  input  N  parallel load data.
- q  output  N  counter register.
- idx  output  IW  decoded phase index (combinational from q and mode_r).
- legal  output  1  q is a legal state for mode_r (combinational).
- tc  output  1  terminal-count pulse (combinational).
- err  output  1  sticky flag: an illegal state was corrected.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: q=1 (only bit 0 set, legal in both modes), mode_r=mode, err=0. Hence idx=2N-1 in Johnson, N-1 in ring.
- mode_r is an internal register sampling mode every cycle.
- Per-cycle priority: rst > load > mode change > illegal correction > en shift > hold.
- load=1: q<=load_val exactly, even if illegal; mode_r<=mode.
- Mode change (mode != mode_r, no load): q<=1, mode_r<=mode; the en shift is suppressed that cycle.
- Correction: if en=1 and legal=0, q<=1 and err<=1 instead of shifting. With en=0, an illegal q holds and err is unchanged.
- Shift when en=1 and legal=1:
  - Johnson right: q<={~q[0], q[N-1:1]}; Johnson left: q<={q[N-2:0], ~q[N-1]}.
  - Ring right: q<={q[0], q[N-1:1]}; ring left: q<={q[N-2:0], q[N-1]}.
  - Latency: 1 cycle from en to new q.
- Legality:
  - Johnson: at most one i in 0..N-2 with q[i]!=q[i+1].
  - Ring: popcount(q)==1.
- idx (p = popcount(q)):
  - Johnson: idx = q[N-1] ? p : (2N-p) mod 2N.
  - Ring: idx = N-1-(position of the set bit).
  - When legal=0, idx=0.
  - Right shift increments idx modulo the period (2N or N); left shift decrements it.
- tc = en & legal & (dir ? idx==0 : idx==period-1). It is suppressed during a load or mode-change cycle.
- err is cleared only by rst.

Decomposition:
- Shared package counters_pkg holds:
  - localparam MODE_JOHNSON=1'b0, MODE_RING=1'b1, DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
  - A function clog2_safe.
- One natural sub-module: shift_ring_decode (pure combinational: q, mode_r -> legal, idx), reusable by other sequence generators.
- Top level holds the registers, priority mux and tc.

Test Plan (N=4):
- Reset then en=1, mode=0, dir=0 for 9 cycles -> q: 0001, 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; idx: 7, 0, 1, 2, 3, 4, 5, 6, 7, 0; tc high in the cycles where idx=7.
- From reset, Johnson, dir=1, en=1 -> q: 0001, 0011, 0111, 1111, 1110; idx: 7, 6, 5, 4, 3; tc high when idx=0.
- Ring mode: load=1, load_val=0001, then en=1, dir=0 -> q: 1000, 0100, 0010, 0001; idx: 0, 1, 2, 3; tc at idx=3. Then dir=1 -> 0010.
- Johnson, load_val=0101 (illegal) -> legal=0, idx=0. en=0 holds q=0101, err=0. Next en=1 cycle -> q=0001, err=1, no tc. err stays 1 until rst.
- Mode change: Johnson at q=1100, mode 0->1 with en=1 -> next q=0001 with no shift; following en cycle -> 1000.
- Simultaneous events: rst=1 with load=1 and en=1 -> q=0001, err=0. load=1 with mode change and en=1 -> q=load_val, tc=0.
